// File: rtl/sensor_uart_rx_if.sv
// Byte handoff between the UART receiver and its consumer.
// The receiver (master) owns data/valid; the consumer (slave) returns ack.
interface sensor_uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ack;

  modport master (output data, output valid, input ack);
  modport slave  (input data, input valid, output ack);
endinterface

// File: rtl/sensor_uart_rx.sv
// sensor_uart_rx: 16x oversampling 8N1 receiver for the sensor link.
// Rejects start glitches, majority-votes samples 7/8/9 of every bit and
// hands bytes to the consumer through a valid/ack holding register.
module sensor_uart_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 38_000
) (
  input  logic clock,
  input  logic reset,
  input  logic rxPin,
  output logic busy,
  output logic frame_err,
  output logic overrun,
  sensor_uart_rx_if.master bus
);

  // Clocks per oversample tick; the design assumes DIV >= 2.
  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      s_q, s_d;
  logic [1:0]      samp_q, samp_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;

  logic            rxs;
  logic            tick;
  logic [7:0]      sIdx;
  logic [3:0]      phase;
  logic            majority;
  logic            goodStop;
  logic            badStop;

  assign rxs      = sync2_q;
  assign tick     = (cnt_q == CW'(DIV - 1));
  assign sIdx     = s_q + 8'd1;
  assign phase    = sIdx[3:0];
  assign majority = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxPin;
      sync2_q <= sync1_q;
    end
  end

  // State register and all datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      samp_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic: tick timing, bit sampling, majority decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    samp_d   = samp_q;
    shift_d  = shift_q;
    goodStop = 1'b0;
    badStop  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        s_d   = '0;
        if (!rxs) state_d = START;
      end
      START, DATA, STOP: begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        if (tick) begin
          s_d = sIdx;
          if (phase == 4'd7) samp_d[0] = rxs;
          if (phase == 4'd8) samp_d[1] = rxs;
          if (phase == 4'd9) begin
            if (state_q == START) begin
              state_d = majority ? IDLE : DATA;
            end else if (state_q == DATA) begin
              shift_d = {majority, shift_q[7:1]};
              if (sIdx == 8'd137) state_d = STOP;
            end else if (majority) begin
              goodStop = 1'b1;
              state_d  = IDLE;
            end else begin
              badStop = 1'b1;
              state_d = WAIT_HIGH;
            end
          end
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: holding register, read handshake and error pulses.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = badStop;
    ovr_d   = 1'b0;
    if (goodStop) begin
      if (!valid_q || bus.ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.ack) begin
      valid_d = 1'b0;
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule
